// File: rtl/jtsdram_vtimer.sv
// jtsdram_vtimer: pixel clock enable divider plus H/V counters with registered,
// zero-skew blanking, sync and line-number outputs for the SDRAM tester display.
module jtsdram_vtimer #(
  parameter int unsigned CEN_DIV  = 8,
  parameter int unsigned HTOTAL   = 384,
  parameter int unsigned HB_START = 256,
  parameter int unsigned HS_START = 296,
  parameter int unsigned HS_LEN   = 32,
  parameter int unsigned VTOTAL   = 262,
  parameter int unsigned VB_START = 240,
  parameter int unsigned VS_START = 248,
  parameter int unsigned VS_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pxl_cen,
  output logic [8:0] hdump,
  output logic [7:0] vdump,
  output logic [8:0] vcnt_full,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS,
  output logic       frame
);
  localparam logic [3:0] DIV_LAST = 4'(CEN_DIV - 1);
  localparam logic [8:0] H_LAST   = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(VTOTAL - 1);
  // Window bounds are 10 bits wide so HS_START+HS_LEN = 512 cannot wrap.
  localparam logic [9:0] HB   = 10'(HB_START);
  localparam logic [9:0] HS_S = 10'(HS_START);
  localparam logic [9:0] HS_E = 10'(HS_START + HS_LEN);
  localparam logic [9:0] VB   = 10'(VB_START);
  localparam logic [9:0] VS_S = 10'(VS_START);
  localparam logic [9:0] VS_E = 10'(VS_START + VS_LEN);

  if (CEN_DIV < 2 || CEN_DIV > 16) begin : g_bad_cen
    $error("jtsdram_vtimer: CEN_DIV must be 2..16");
  end
  if (HB_START >= HTOTAL) begin : g_bad_hb
    $error("jtsdram_vtimer: HB_START must be below HTOTAL");
  end
  if (HS_START + HS_LEN > HTOTAL) begin : g_bad_hs
    $error("jtsdram_vtimer: HS window exceeds HTOTAL");
  end
  if (VB_START >= VTOTAL) begin : g_bad_vb
    $error("jtsdram_vtimer: VB_START must be below VTOTAL");
  end
  if (VS_START + VS_LEN > VTOTAL) begin : g_bad_vs
    $error("jtsdram_vtimer: VS window exceeds VTOTAL");
  end
  if (HTOTAL > 512 || VTOTAL > 512) begin : g_bad_tot
    $error("jtsdram_vtimer: HTOTAL and VTOTAL must not exceed 512");
  end

  logic [3:0] div_q, div_d;
  logic       cen_q;
  logic [8:0] h_q, h_d, v_q, v_d;
  logic       lhbl_q, lvbl_q, hs_q, vs_q, frame_q;
  logic       h_wrap, v_wrap;

  always_comb begin
    div_d  = div_q == DIV_LAST ? 4'd0 : div_q + 4'd1;
    h_wrap = h_q == H_LAST;
    v_wrap = v_q == V_LAST;
    h_d    = h_wrap ? 9'd0 : h_q + 9'd1;
    v_d    = !h_wrap ? v_q : v_wrap ? 9'd0 : v_q + 9'd1;
  end

  // Decodes use the next counter values so they land on the same edge as the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= 4'd0;
      cen_q   <= 1'b0;
      h_q     <= 9'd0;
      v_q     <= 9'd0;
      lhbl_q  <= 1'b1;
      lvbl_q  <= 1'b1;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cen_q <= div_q == DIV_LAST;
      if (cen_q) begin
        h_q     <= h_d;
        v_q     <= v_d;
        lhbl_q  <= {1'b0, h_d} < HB;
        lvbl_q  <= {1'b0, v_d} < VB;
        hs_q    <= {1'b0, h_d} >= HS_S && {1'b0, h_d} < HS_E;
        vs_q    <= {1'b0, v_d} >= VS_S && {1'b0, v_d} < VS_E;
        frame_q <= frame_q ^ (h_wrap & v_wrap);
      end
    end
  end

  assign pxl_cen   = cen_q;
  assign hdump     = h_q;
  assign vcnt_full = v_q;
  assign vdump     = v_q[7:0];
  assign LHBL      = lhbl_q;
  assign LVBL      = lvbl_q;
  assign HS        = hs_q;
  assign VS        = vs_q;
  assign frame     = frame_q;
endmodule

// File: tb/tb_jtsdram_vtimer.sv
// tb_jtsdram_vtimer: scoreboard bench over three parameterisations of jtsdram_vtimer,
// keyed by the advance count since the last reset release.
module tb_jtsdram_vtimer;
  typedef logic [30:0] obs_t;
  typedef struct packed { int id; int n; obs_t o; } exp_t;
  localparam obs_t RST_O = {9'd0, 9'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst_n;
  logic [2:0] pxl, lh, lv, hs, vs, fr;
  logic [2:0][8:0] h, vf;
  logic [2:0][7:0] vd;
  int total = 0, bad = 0;
  int cen [3] = '{8, 2, 2};
  int cyc [3], last [3], adv [3];
  bit first [3];
  obs_t prev [3];
  logic [2:0] pc_s;
  exp_t sb [$];

  jtsdram_vtimer u_d (.clk(clk), .rst_n(rst_n[0]), .pxl_cen(pxl[0]), .hdump(h[0]), .vdump(vd[0]),
    .vcnt_full(vf[0]), .LHBL(lh[0]), .LVBL(lv[0]), .HS(hs[0]), .VS(vs[0]), .frame(fr[0]));
  jtsdram_vtimer #(.CEN_DIV(2), .HTOTAL(16), .HB_START(12), .HS_START(8), .HS_LEN(4)) u_m (
    .clk(clk), .rst_n(rst_n[1]), .pxl_cen(pxl[1]), .hdump(h[1]), .vdump(vd[1]),
    .vcnt_full(vf[1]), .LHBL(lh[1]), .LVBL(lv[1]), .HS(hs[1]), .VS(vs[1]), .frame(fr[1]));
  jtsdram_vtimer #(.CEN_DIV(2), .HTOTAL(16), .HB_START(12), .HS_START(13), .HS_LEN(2),
    .VTOTAL(8), .VB_START(6), .VS_START(6), .VS_LEN(1)) u_v (
    .clk(clk), .rst_n(rst_n[2]), .pxl_cen(pxl[2]), .hdump(h[2]), .vdump(vd[2]),
    .vcnt_full(vf[2]), .LHBL(lh[2]), .LVBL(lv[2]), .HS(hs[2]), .VS(vs[2]), .frame(fr[2]));

  function automatic obs_t ob(int g);
    return {h[g], vf[g], vd[g], lh[g], lv[g], hs[g], vs[g], fr[g]};
  endfunction

  task automatic chk(string nm, int g, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h", nm, g, got, want);
    end
  endtask

  task automatic push(int id, int n, int hh, int vv, int vdd, bit l, bit lvv, bit hss, bit vss, bit f);
    sb.push_back('{id, n, {9'(hh), 9'(vv), 8'(vdd), l, lvv, hss, vss, f}});
  endtask

  always @(posedge clk)
    for (int g = 0; g < 3; g++) begin
      pc_s[g] <= rst_n[g] & pxl[g];
      cyc[g]  <= rst_n[g] ? cyc[g] + 1 : 0;
    end

  always @(negedge clk)
    for (int g = 0; g < 3; g++) begin
      if (!rst_n[g]) begin
        adv[g] = 0;
        first[g] = 1'b1;
        chk("reset_state", g, {1'b0, ob(g)}, {1'b0, RST_O});
        chk("reset_cen", g, {31'd0, pxl[g]}, 32'd0);
      end else begin
        if (pxl[g]) begin
          chk(first[g] ? "first_cen" : "cen_period", g, first[g] ? cyc[g] : cyc[g] - last[g], cen[g]);
          last[g] = cyc[g];
          first[g] = 1'b0;
        end
        if (pc_s[g]) begin
          adv[g]++;
          for (int i = 0; i < sb.size(); i++)
            if (sb[i].id == g) begin
              if (sb[i].n == adv[g]) begin
                chk($sformatf("adv%0d", adv[g]), g, {1'b0, ob(g)}, {1'b0, sb[i].o});
                sb.delete(i);
              end
              break;
            end
        end else chk("hold", g, {1'b0, ob(g)}, {1'b0, prev[g]});
      end
      prev[g] = ob(g);
    end

  always @(negedge rst_n[1])
    if ($time > 100) begin
      #1;
      chk("async_reset", 1, {1'b0, ob(1)}, {1'b0, RST_O});
      chk("async_reset_cen", 1, {31'd0, pxl[1]}, 32'd0);
    end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 3'b000;
    push(0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    push(0, 255, 255, 0, 0, 1, 1, 0, 0, 0);
    push(0, 256, 256, 0, 0, 0, 1, 0, 0, 0);
    push(0, 295, 295, 0, 0, 0, 1, 0, 0, 0);
    push(0, 296, 296, 0, 0, 0, 1, 1, 0, 0);
    push(0, 327, 327, 0, 0, 0, 1, 1, 0, 0);
    push(0, 328, 328, 0, 0, 0, 1, 0, 0, 0);
    push(0, 383, 383, 0, 0, 0, 1, 0, 0, 0);
    push(0, 384, 0, 1, 1, 1, 1, 0, 0, 0);
    push(0, 385, 1, 1, 1, 1, 1, 0, 0, 0);
    push(1, 3839, 15, 239, 239, 0, 1, 0, 0, 0);
    push(1, 3840, 0, 240, 240, 1, 0, 0, 0, 0);
    push(1, 3967, 15, 247, 247, 0, 0, 0, 0, 0);
    push(1, 3968, 0, 248, 248, 1, 0, 0, 1, 0);
    push(1, 4015, 15, 250, 250, 0, 0, 0, 1, 0);
    push(1, 4016, 0, 251, 251, 1, 0, 0, 0, 0);
    push(1, 4080, 0, 255, 255, 1, 0, 0, 0, 0);
    push(1, 4096, 0, 256, 0, 1, 0, 0, 0, 0);
    push(1, 4191, 15, 261, 5, 0, 0, 0, 0, 0);
    push(1, 4192, 0, 0, 0, 1, 1, 0, 0, 1);
    push(1, 4200, 8, 0, 0, 1, 1, 1, 0, 1);
    push(1, 4203, 11, 0, 0, 1, 1, 1, 0, 1);
    push(1, 4204, 12, 0, 0, 0, 1, 0, 0, 1);
    push(1, 5797, 5, 100, 100, 1, 1, 0, 0, 1);
    push(2, 11, 11, 0, 0, 1, 1, 0, 0, 0);
    push(2, 12, 12, 0, 0, 0, 1, 0, 0, 0);
    push(2, 13, 13, 0, 0, 0, 1, 1, 0, 0);
    push(2, 14, 14, 0, 0, 0, 1, 1, 0, 0);
    push(2, 15, 15, 0, 0, 0, 1, 0, 0, 0);
    push(2, 16, 0, 1, 1, 1, 1, 0, 0, 0);
    push(2, 96, 0, 6, 6, 1, 0, 0, 1, 0);
    push(2, 111, 15, 6, 6, 0, 0, 0, 1, 0);
    push(2, 112, 0, 7, 7, 1, 0, 0, 0, 0);
    push(2, 128, 0, 0, 0, 1, 1, 0, 0, 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 3'b111;
    for (int i = 0; i < 20000 && adv[1] != 5797; i++) begin
      @(negedge clk);
      #1;
    end
    chk("reach_line100", 1, adv[1], 5797);
    #1 rst_n[1] = 1'b0;
    @(negedge clk);
    #2 rst_n[1] = 1'b1;
    push(1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    push(1, 8, 8, 0, 0, 1, 1, 1, 0, 0);
    push(1, 16, 0, 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2000 && !(adv[1] >= 16 && adv[0] >= 385); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 0, sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
